// File: rtl/instr_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_mem_pkg                                                 |
// | Purpose  : Shared constants and FSM state encoding for the instruction   |
// |            memory (size, address width, NOP word, LOAD/RUN states).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package instr_mem_pkg;

  localparam int          MEM_BYTES = 1024;
  localparam int          ADDR_W    = 10;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_mem_ram                                                 |
// | Purpose  : Byte-wide storage array with a synchronous byte write port    |
// |            and a registered 4-byte little-endian read port.              |
// | Ports    : clk            - rising-edge clock                            |
// |            we/waddr/wdata - byte write                                   |
// |            re/raddr       - word read request (byte address)            |
// |            rdata          - registered word, updated only when re=1     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module instr_mem_ram #(
  parameter int MEM_BYTES = instr_mem_pkg::MEM_BYTES,
  parameter int ADDR_W    = instr_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  // Contents are deliberately not reset: a reload only overwrites the
  // bytes it actually touches.
  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Callers only request aligned words, so raddr+3 never passes the top.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= {mem[raddr + ADDR_W'(3)], mem[raddr + ADDR_W'(2)],
                mem[raddr + ADDR_W'(1)], mem[raddr]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_mem                                                     |
// | Purpose  : Loadable instruction memory. After reset it accepts a byte    |
// |            stream (LOAD), then services 1-cycle word fetches (RUN).      |
// | Ports    : clk, reset (sync, active-high)                                |
// |            load_valid/load_byte/load_done -> load_ready                  |
// |            fetch_en/addr -> instr, instr_valid, misaligned               |
// |            run - high once the image is loaded                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module instr_mem #(
  parameter int          MEM_BYTES = instr_mem_pkg::MEM_BYTES,
  parameter int          ADDR_W    = instr_mem_pkg::ADDR_W,
  parameter logic [31:0] NOP_WORD  = instr_mem_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_done,
  output logic              load_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              run
);
  import instr_mem_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              use_nop;   // instr shows NOP_WORD instead of RAM data
  logic [31:0]       ram_rdata;
  logic              ram_we;
  logic              ram_re;
  logic              fetch_ok;
  logic              addr_mis;

  assign fetch_ok = (state == ST_RUN) && fetch_en;
  assign addr_mis = (addr[1:0] != 2'b00);

  // Reset gates both ports so it overrides every other input.
  assign ram_we = !reset && (state == ST_LOAD) && load_valid;
  assign ram_re = !reset && fetch_ok && !addr_mis;

  instr_mem_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ptr),
    .wdata (load_byte),
    .re    (ram_re),
    .raddr (addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      ptr         <= '0;
      use_nop     <= 1'b1;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      instr_valid <= fetch_ok;
      misaligned  <= fetch_ok && addr_mis;
      // use_nop only changes on a serviced fetch, so instr holds otherwise.
      if (fetch_ok) begin
        use_nop <= addr_mis;
      end
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            ptr <= ptr + ADDR_W'(1);
          end
          // Writing the last byte ends the load instead of wrapping ptr.
          if (load_done || (load_valid && (ptr == LAST_PTR))) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;  // RUN is left only by reset
      endcase
    end
  end

  // The RAM read register doubles as the instr register; the flag selects
  // between it and the NOP word, keeping the fetch latency at one cycle.
  assign instr      = use_nop ? NOP_WORD : ram_rdata;
  assign load_ready = (state == ST_LOAD);
  assign run        = (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_mem                                                  |
// | Purpose  : Self-checking bench for instr_mem against a byte-array        |
// |            reference model, with directed and randomized stimulus.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instr_mem;

  localparam int          MB  = 1024;
  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_done;
  logic          load_ready;
  logic          fetch_en;
  logic [AW-1:0] addr;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          misaligned;
  logic          run;

  always #5 clk = ~clk;

  instr_mem #(.MEM_BYTES(MB), .ADDR_W(AW), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_done   (load_done),
    .load_ready  (load_ready),
    .fetch_en    (fetch_en),
    .addr        (addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .run         (run)
  );

  // Reference model: plain byte array plus a loaded/running flag.
  logic [7:0]  m_mem   [MB];
  bit          m_known [MB];
  bit          m_run;
  int          m_ptr;
  logic [31:0] m_instr;
  bit          m_instr_known;
  bit          m_valid;
  bit          m_mis;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img [MB];  // last full image loaded

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit lv, input logic [7:0] lb,
                            input bit ld, input bit fe, input int a);
    if (r) begin
      m_run = 0; m_ptr = 0; m_instr = NOP; m_instr_known = 1;
      m_valid = 0; m_mis = 0;
      return;
    end
    m_valid = 0;
    m_mis   = 0;
    if (m_run && fe) begin
      m_valid = 1;
      if (a % 4 != 0) begin
        m_mis = 1; m_instr = NOP; m_instr_known = 1;
      end else begin
        m_instr_known = m_known[a] && m_known[a+1] && m_known[a+2] && m_known[a+3];
        m_instr = {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
      end
    end
    if (!m_run) begin
      if (lv) begin
        m_mem[m_ptr] = lb;
        m_known[m_ptr] = 1;
        if (m_ptr == MB - 1) m_run = 1;
        m_ptr++;
      end
      if (ld) m_run = 1;
    end
  endtask

  // One clock: drive after the falling edge, model the rising edge, then
  // compare on the next falling edge.
  task automatic step(input bit r, input bit lv, input logic [7:0] lb,
                      input bit ld, input bit fe, input int a);
    reset = r; load_valid = lv; load_byte = lb; load_done = ld;
    fetch_en = fe; addr = AW'(a);
    @(posedge clk);
    model_edge(r, lv, lb, ld, fe, a);
    @(negedge clk);
    check_eq("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
    check_eq("run", {31'b0, run}, {31'b0, m_run});
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check_eq("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    if (m_instr_known) check_eq("instr", instr, m_instr);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [8];
    logic [31:0] exp_w;
    logic [7:0] b3;
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < MB; i++) m_known[i] = 0;
    m_run = 0; m_ptr = 0; m_instr = NOP; m_instr_known = 0;

    // Reset state
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_ready", {31'b0, load_ready}, 32'd1);

    // Short program, load_done on the 8th byte
    for (int i = 0; i < 8; i++) step(0, 1, prog[i], (i == 7), 0, 0);
    check_eq("prog_run", {31'b0, run}, 32'd1);
    step(0, 0, 8'h00, 0, 1, 0);
    check_eq("prog_w0", instr, 32'h0000_0013);
    step(0, 0, 8'h00, 0, 1, 4);
    check_eq("prog_w4", instr, 32'h0010_0093);

    // Misaligned fetch, then aligned
    step(0, 0, 8'h00, 0, 1, 6);
    check_eq("mis_flag", {31'b0, misaligned}, 32'd1);
    check_eq("mis_instr", instr, NOP);
    step(0, 0, 8'h00, 0, 1, 8);
    check_eq("mis_clear", {31'b0, misaligned}, 32'd0);
    idle();

    // Back-to-back fetches
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1, 4 * i);
    idle();

    // Fetch during LOAD, and load_valid with load_done together
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h5a, 0, 1, 0);
    check_eq("load_fetch_valid", {31'b0, instr_valid}, 32'd0);
    step(0, 1, 8'ha5, 1, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    check_eq("done_byte", instr, {8'h00, 8'h00, 8'ha5, 8'h5a});

    // Full 1024-byte load with no load_done
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < MB; i++) begin
      img[i] = 8'($urandom);
      step(0, 1, img[i], 0, ($urandom % 2) == 1, $urandom % MB);
    end
    check_eq("full_run", {31'b0, run}, 32'd1);
    step(0, 0, 8'h00, 0, 1, 1020);
    check_eq("full_top", instr, {img[1023], img[1022], img[1021], img[1020]});

    // Random traffic in RUN; load inputs must be ignored
    for (int i = 0; i < 300; i++)
      step(0, ($urandom % 2) == 1, 8'($urandom), ($urandom % 4) == 0,
           ($urandom % 4) != 0, ($urandom % 3 == 0) ? $urandom % MB : 4 * ($urandom % 256));

    // Reset mid-load, reload over the bottom; old bytes above remain
    b3 = img[3];
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'haa, 0, 0, 0);
    step(0, 1, 8'hbb, 0, 0, 0);
    step(0, 1, 8'hcc, 0, 0, 0);
    step(1, 1, 8'hee, 0, 0, 0);
    check_eq("reload_ready", {31'b0, load_ready}, 32'd1);
    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 1, 8'h22, 1, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    exp_w = {b3, 8'hcc, 8'h22, 8'h11};
    check_eq("reload_w0", instr, exp_w);

    // Reset during a run drops the fetch in flight
    step(0, 0, 8'h00, 0, 1, 4);
    step(1, 0, 8'h00, 0, 1, 0);
    check_eq("run_rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("run_rst_instr", instr, NOP);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter MEM_BYTES, default 1024; memory size in bytes, matching the 10-bit program-counter address space.
REQ-002 Parameter ADDR_W, default 10; fetch/load address width.
REQ-003 Parameter NOP_WORD, default 32'h00000013; word returned on a rejected fetch (RV32I addi x0,x0,0).
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_valid  input  1  loader presents one program byte this cycle.
REQ-007 load_byte  input  8  program byte, written at the current load pointer.
REQ-008 load_done  input  1  loader signals end of image.
REQ-009 load_ready  output  1  high while in LOAD state; bytes are accepted.
REQ-010 fetch_en  input  1  fetch request from the core.
REQ-011 addr  input  ADDR_W  byte fetch address, driven by the program counter.
REQ-012 instr  output  32  fetched instruction word, little-endian.
REQ-013 instr_valid  output  1  instr holds a completed fetch this cycle.
REQ-014 misaligned  output  1  the completed fetch had addr[1:0] != 0.
REQ-015 run  output  1  high in RUN state; fetches are serviced.

Function
REQ-016 Two-state FSM: LOAD (after reset) and RUN.
REQ-017 LOAD: when load_valid=1, mem[ptr] <= load_byte and ptr <= ptr+1; ptr is ADDR_W bits wide.
REQ-018 LOAD -> RUN on load_done=1, or on a write at ptr = MEM_BYTES-1; ptr does not wrap to 0 in LOAD.
REQ-019 load_valid and load_done in the same cycle: the byte is written first, then the FSM enters RUN the next cycle.
REQ-020 RUN: load_valid and load_done are ignored; memory is read-only; RUN is left only by reset.
REQ-021 Fetch latency is 1 cycle: fetch_en=1 at edge N makes instr and instr_valid valid after edge N+1.
REQ-022 Aligned fetch: instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, misaligned=0.
REQ-023 Misaligned fetch (addr[1:0] != 0): instr = NOP_WORD, instr_valid=1, misaligned=1 for that cycle only.
REQ-024 Aligned addresses never cross the top of memory; addr=1020 returns bytes 1020..1023.
REQ-025 fetch_en=0, or fetch_en in LOAD: instr_valid=0, misaligned=0, instr holds its last value.
REQ-026 fetch_en held high: one new result per cycle; the address may change every cycle (back-to-back fetches).
REQ-027 load_ready = (state==LOAD); run = (state==RUN); both combinational from the state.

Reset
REQ-028 On reset: state=LOAD, ptr=0, instr=NOP_WORD, instr_valid=0, misaligned=0; hence load_ready=1 and run=0.
REQ-029 Reset mid-load or mid-run takes effect at the next edge and overrides all other inputs; a fetch in flight is dropped.
REQ-030 Memory array contents are not cleared by reset; bytes not reloaded keep their prior values.

Structure
REQ-031 Shared package holds MEM_BYTES, ADDR_W, NOP_WORD and the LOAD/RUN state encoding.
REQ-032 One sub-module, instr_mem_ram: byte-wide synchronous-write array with a registered 4-byte read port; the FSM, load pointer and output logic stay in instr_mem.

Verification
REQ-033 Reset, then load bytes 13 00 00 00 93 00 10 00 with load_done on the 8th -> load_ready falls, run=1 next cycle; fetch addr=0 -> instr=00000013 one cycle later; addr=4 -> 00100093.
REQ-034 Load 1024 bytes without load_done -> RUN entered after byte 1023; fetch addr=1020 returns the last four loaded bytes, little-endian.
REQ-035 In RUN, fetch addr=6 -> instr=00000013, instr_valid=1, misaligned=1 for exactly one cycle; next fetch addr=8 -> misaligned=0.
REQ-036 fetch_en=1 during LOAD -> instr_valid stays 0; load_valid with load_done in one cycle -> that byte is readable at its address after RUN.
REQ-037 Back-to-back fetch_en with addr 0,4,8,12 -> four consecutive instr_valid cycles, each word one cycle after its address.
REQ-038 Reset asserted after 3 loaded bytes -> ptr=0, load_ready=1; reload writes over from address 0; old bytes above the new image remain.
